window_ctrl: RTL and testbench

WINDOW_CTRL -- requirements
Module: window_ctrl

---
 rtl/window_ctrl.sv | 123 ++++++++++++
 tb/tb_window_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/window_ctrl.sv
// Register-window controller: CWP/WIM state with save/restore/trap stepping.
// Define WINDOW_TRAP_EN to enable WIM overflow/underflow checking and the WTRAP state.
module window_ctrl #(
  parameter int unsigned NWIN = 8,
  parameter int unsigned CWPW = 3
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            save,
  input  logic            restore,
  input  logic            trap,
  input  logic            cwp_we,
  input  logic [CWPW-1:0] cwp_d,
  input  logic            wim_we,
  input  logic [NWIN-1:0] wim_d,
  input  logic            trap_ack,
  output logic [CWPW-1:0] cwp,
  output logic [NWIN-1:0] wim,
  output logic            trap_req,
  output logic [1:0]      trap_type,
  output logic            op_done,
  output logic            busy
);

  logic [CWPW-1:0] cwp_dec;
  logic [CWPW-1:0] cwp_inc;
  logic [CWPW-1:0] cwp_wr;

  always_comb begin
    cwp_dec = (cwp == '0) ? CWPW'(NWIN - 1) : cwp - CWPW'(1);
    cwp_inc = (cwp == CWPW'(NWIN - 1)) ? '0 : cwp + CWPW'(1);
    // Out-of-range writes fold back into the legal window range.
    cwp_wr  = CWPW'(32'(cwp_d) % NWIN);
  end

`ifdef WINDOW_TRAP_EN
  typedef enum logic [0:0] {StIdle, StWtrap} state_e;
  state_e state;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state     <= StIdle;
      cwp       <= '0;
      wim       <= '0;
      trap_req  <= 1'b0;
      trap_type <= 2'b00;
      op_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      op_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cwp_we || wim_we) begin
            if (cwp_we) cwp <= cwp_wr;
            if (wim_we) wim <= wim_d;
          end else if (trap) begin
            cwp     <= cwp_dec;
            op_done <= 1'b1;
          end else if (save) begin
            if (wim[cwp_dec]) begin
              trap_req  <= 1'b1;
              trap_type <= 2'b01;
              busy      <= 1'b1;
              state     <= StWtrap;
            end else begin
              cwp     <= cwp_dec;
              op_done <= 1'b1;
            end
          end else if (restore) begin
            if (wim[cwp_inc]) begin
              trap_req  <= 1'b1;
              trap_type <= 2'b10;
              busy      <= 1'b1;
              state     <= StWtrap;
            end else begin
              cwp     <= cwp_inc;
              op_done <= 1'b1;
            end
          end
        end
        StWtrap: begin
          // The trap handler's own window entry happens on acknowledge.
          if (trap_ack) begin
            cwp       <= cwp_dec;
            trap_req  <= 1'b0;
            trap_type <= 2'b00;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
`else
  logic unused_trap_ack;
  assign unused_trap_ack = trap_ack;
  assign trap_req        = 1'b0;
  assign trap_type       = 2'b00;
  assign busy            = 1'b0;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      cwp     <= '0;
      wim     <= '0;
      op_done <= 1'b0;
    end else begin
      op_done <= 1'b0;
      if (cwp_we || wim_we) begin
        if (cwp_we) cwp <= cwp_wr;
        if (wim_we) wim <= wim_d;
      end else if (trap || save) begin
        cwp     <= cwp_dec;
        op_done <= 1'b1;
      end else if (restore) begin
        cwp     <= cwp_inc;
        op_done <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_window_ctrl.sv
// Directed, table-driven bench for window_ctrl (NWIN=8); expectations follow WINDOW_TRAP_EN.
module tb_window_ctrl;
  localparam int unsigned NWIN = 8;
  localparam int unsigned CWPW = 3;
`ifdef WINDOW_TRAP_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic            Clk = 1'b0;
  logic            Clr = 1'b0;
  logic            save = 1'b0;
  logic            restore = 1'b0;
  logic            trap = 1'b0;
  logic            cwp_we = 1'b0;
  logic [CWPW-1:0] cwp_d = '0;
  logic            wim_we = 1'b0;
  logic [NWIN-1:0] wim_d = '0;
  logic            trap_ack = 1'b0;
  logic [CWPW-1:0] cwp;
  logic [NWIN-1:0] wim;
  logic            trap_req;
  logic [1:0]      trap_type;
  logic            op_done;
  logic            busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       clr, sv, rs, tp, cwe;
    logic [2:0] cd;
    logic       wwe;
    logic [7:0] wd;
    logic       ack;
    logic [2:0] ecwp;
    logic [7:0] ewim;
    logic       eod, etr;
    logic [1:0] ett;
  } vec_t;

  vec_t tbl[$];

  window_ctrl #(.NWIN(NWIN), .CWPW(CWPW)) dut (
    .Clk(Clk), .Clr(Clr), .save(save), .restore(restore), .trap(trap),
    .cwp_we(cwp_we), .cwp_d(cwp_d), .wim_we(wim_we), .wim_d(wim_d), .trap_ack(trap_ack),
    .cwp(cwp), .wim(wim), .trap_req(trap_req), .trap_type(trap_type),
    .op_done(op_done), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input int clr, input int sv, input int rs, input int tp, input int cwe,
                     input int cd, input int wwe, input int wd, input int ack,
                     input int ecwp, input int ewim, input int eod, input int etr,
                     input int ett);
    vec_t v;
    v.clr = 1'(clr); v.sv = 1'(sv); v.rs = 1'(rs); v.tp = 1'(tp); v.cwe = 1'(cwe);
    v.cd = 3'(cd); v.wwe = 1'(wwe); v.wd = 8'(wd); v.ack = 1'(ack);
    v.ecwp = 3'(ecwp); v.ewim = 8'(ewim); v.eod = 1'(eod); v.etr = 1'(etr); v.ett = 2'(ett);
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    Clr = v.clr; save = v.sv; restore = v.rs; trap = v.tp; cwp_we = v.cwe;
    cwp_d = v.cd; wim_we = v.wwe; wim_d = v.wd; trap_ack = v.ack;
  endtask

  task automatic idle_inputs();
    Clr = 0; save = 0; restore = 0; trap = 0; cwp_we = 0; cwp_d = '0;
    wim_we = 0; wim_d = '0; trap_ack = 0;
  endtask

  task automatic check_all(input string tag, input int idx, input int ecwp, input int ewim,
                           input int eod, input int etr, input int ett);
    chk({tag, ".cwp"}, idx, 32'(cwp), 32'(ecwp));
    chk({tag, ".wim"}, idx, 32'(wim), 32'(ewim));
    chk({tag, ".op_done"}, idx, 32'(op_done), 32'(eod));
    chk({tag, ".trap_req"}, idx, 32'(trap_req), 32'(etr));
    chk({tag, ".trap_type"}, idx, 32'(trap_type), 32'(ett));
    chk({tag, ".busy"}, idx, 32'(busy), 32'(etr));
  endtask

  initial begin
    int t = int'(TE);
    int n = int'(!TE);
    bit seen;
    //  clr sv rs tp cwe cd wwe wd   ack  cwp        wim  od etr ett
    add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0,   0,         8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0,   7,         8'h00, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0,   6,         8'h00, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0,   5,         8'h00, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0,   5,         8'h00, 0, 0, 0);
    add(0, 0, 0, 0, 1, 6, 1, 8'h20, 0,   6,         8'h20, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0,   TE ? 6 : 5, 8'h20, n, t, t);
    add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0,   TE ? 6 : 4, 8'h20, n, t, t);
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1,   TE ? 5 : 4, 8'h20, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1,   TE ? 5 : 4, 8'h20, 0, 0, 0);
    add(0, 0, 0, 0, 1, 7, 1, 8'h01, 0,   7,         8'h01, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00, 0,   TE ? 7 : 0, 8'h01, n, t, 2 * t);
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1,   TE ? 6 : 0, 8'h01, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 8'h00, 0,   TE ? 6 : 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 0, 1, 7, 0, 8'h00, 0,   7,         8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00, 0,   0,         8'h00, 1, 0, 0);
    add(0, 1, 0, 0, 1, 3, 0, 8'h00, 0,   3,         8'h00, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 8'h00, 0,   2,         8'h00, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 0,   1,         8'h00, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00, 0,   2,         8'h00, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 8'hFF, 0,   2,         8'hFF, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 8'h00, 0,   1,         8'hFF, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0,   TE ? 1 : 0, 8'hFF, n, t, t);
    add(1, 1, 0, 0, 0, 0, 0, 8'h00, 1,   0,         8'h00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 1,   0,         8'h00, 0, 0, 0);
    add(1, 1, 1, 1, 1, 5, 1, 8'h0F, 0,   0,         8'h00, 0, 0, 0);

    idle_inputs();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge Clk);
      drive(tbl[i]);
      @(posedge Clk);
      #1;
      check_all("vec", i, int'(tbl[i].ecwp), int'(tbl[i].ewim), int'(tbl[i].eod),
                int'(tbl[i].etr), int'(tbl[i].ett));
    end

    // Long WTRAP dwell: writes and operations must not disturb the pending trap.
    @(negedge Clk);
    idle_inputs();
    cwp_we = 1; cwp_d = 3'd4; wim_we = 1; wim_d = 8'h08;
    @(negedge Clk);
    idle_inputs();
    save = 1;
    @(negedge Clk);
    check_all("dwell0", 0, TE ? 4 : 3, 8'h08, n, t, t);
    for (int k = 1; k <= 3; k++) begin
      idle_inputs();
      cwp_we = 1; cwp_d = 3'd1; wim_we = 1; wim_d = 8'h00; restore = 1; trap = 1;
      @(negedge Clk);
      check_all("dwell", k, TE ? 4 : 1, TE ? 8'h08 : 8'h00, 0, t, t);
    end
    idle_inputs();
    trap_ack = 1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge Clk);
      trap_ack = 0;
      if (!busy) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL busy_release: got busy=%0b want 0 within 4 cycles", busy);
    end
    check_all("ack", 0, TE ? 3 : 1, TE ? 8'h08 : 8'h00, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
